// File: rtl/bg_trim_monitor.sv
// Captures bandgap trim results, judges lock over consecutive results and
// streams each capture off-chip as a three-byte UART 8N1 frame.
module bg_trim_monitor #(
  parameter int CLK_DIV  = 87,
  parameter int STABLE_N = 4,
  parameter int FINE_TOL = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        valid,
  input  logic [7:0]  idac_coarse,
  input  logic [7:0]  idac_fine,
  input  logic        clr_overrun,
  output logic        tx,
  output logic        busy,
  output logic        locked,
  output logic [15:0] code,
  output logic        overrun
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [3:0] CNT_MAX  = 4'(STABLE_N);
  localparam logic [8:0] TOL      = 9'(FINE_TOL);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  // Capture and lock tracking
  logic        r_valid_d;
  logic        r_have_prev;
  logic [3:0]  r_stable_cnt;
  logic        r_locked;
  logic [15:0] r_code;

  // One-deep pending frame slot
  logic        r_pending;
  logic [23:0] r_pend_data;
  logic [2:0]  r_seq;
  logic        r_overrun;

  // UART transmitter
  state_t      r_state;
  logic [7:0]  r_baud;
  logic [2:0]  r_bit_idx;
  logic [1:0]  r_byte_idx;
  logic [23:0] r_frame;
  logic [7:0]  r_shift;
  logic        r_tx;

  logic        w_capture;
  logic [8:0]  w_fine_diff;
  logic        w_stable;
  logic [3:0]  w_cnt_next;
  logic        w_locked_new;
  logic        w_load;
  logic        w_bit_end;

  assign w_capture = en & valid & ~r_valid_d;

  // Unsigned magnitude in 9 bits so 0x00 vs 0xFF reads as 255, never 1.
  always_comb begin
    if (idac_fine >= r_code[7:0]) begin
      w_fine_diff = {1'b0, idac_fine} - {1'b0, r_code[7:0]};
    end else begin
      w_fine_diff = {1'b0, r_code[7:0]} - {1'b0, idac_fine};
    end
  end

  assign w_stable = (idac_coarse == r_code[15:8]) && (w_fine_diff <= TOL);

  always_comb begin
    w_cnt_next = '0;
    if (r_have_prev && w_stable) begin
      w_cnt_next = (r_stable_cnt == CNT_MAX) ? CNT_MAX : r_stable_cnt + 4'd1;
    end
  end

  assign w_locked_new = (w_cnt_next == CNT_MAX);
  assign w_load       = (r_state == ST_IDLE) && r_pending;
  assign w_bit_end    = (r_baud == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid_d <= 1'b0;
    end else begin
      r_valid_d <= valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_have_prev  <= 1'b0;
      r_stable_cnt <= '0;
      r_locked     <= 1'b0;
      r_code       <= '0;
    end else if (!en) begin
      r_have_prev  <= 1'b0;
      r_stable_cnt <= '0;
      r_locked     <= 1'b0;
    end else if (w_capture) begin
      r_have_prev  <= 1'b1;
      r_stable_cnt <= w_cnt_next;
      r_locked     <= w_locked_new;
      r_code       <= {idac_coarse, idac_fine};
    end
  end

  // A capture on the load edge refills the slot the transmitter is emptying.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending   <= 1'b0;
      r_pend_data <= '0;
      r_seq       <= '0;
    end else if (w_capture) begin
      r_pending   <= 1'b1;
      r_pend_data <= {4'hA, w_locked_new, r_seq, idac_coarse, idac_fine};
      r_seq       <= r_seq + 3'd1;
    end else if (w_load) begin
      r_pending   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_capture && r_pending && !w_load) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_frame    <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
    end else begin
      if (r_state != ST_IDLE) begin
        r_baud <= w_bit_end ? 8'd0 : r_baud + 8'd1;
      end
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (r_pending) begin
            r_frame    <= r_pend_data;
            r_byte_idx <= '0;
            r_baud     <= '0;
            r_tx       <= 1'b0;
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_tx      <= r_frame[16];
            r_shift   <= {1'b0, r_frame[23:17]};
            r_bit_idx <= '0;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            if (r_byte_idx == 2'd2) begin
              r_state <= ST_IDLE;
            end else begin
              r_byte_idx <= r_byte_idx + 2'd1;
              r_frame    <= {r_frame[15:0], 8'h00};
              r_tx       <= 1'b0;
              r_state    <= ST_START;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx      = r_tx;
  assign busy    = r_pending | (r_state != ST_IDLE);
  assign locked  = r_locked;
  assign code    = r_code;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_bg_trim_monitor.sv
// Randomised scoreboard bench: a frame-level model predicts each UART frame,
// a UART receiver decodes tx and compares against the expected queue.
module tb_bg_trim_monitor;

  localparam int CD        = 4;
  localparam int SN        = 4;
  localparam int FT        = 1;
  localparam int FRAME_CYC = 30 * CD;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  idac_coarse = 8'h00;
  logic [7:0]  idac_fine = 8'h00;
  logic        clr_overrun = 1'b0;
  logic        tx;
  logic        busy;
  logic        locked;
  logic [15:0] code;
  logic        overrun;

  int n_vec = 0;
  int n_bad = 0;

  bg_trim_monitor #(
    .CLK_DIV (CD),
    .STABLE_N(SN),
    .FINE_TOL(FT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .valid      (valid),
    .idac_coarse(idac_coarse),
    .idac_fine  (idac_fine),
    .clr_overrun(clr_overrun),
    .tx         (tx),
    .busy       (busy),
    .locked     (locked),
    .code       (code),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: captures, lock history and a frame-time countdown.
  bit          m_valid_d, m_have_prev, m_locked, m_pend, m_overrun;
  int          m_cnt, m_seq, m_remaining;
  logic [15:0] m_code;
  logic [23:0] m_pend_data;
  logic [23:0] exp_q[$];
  bit          s_cap, s_ld, s_pend_before, s_set;
  int          s_diff;

  initial begin
    m_valid_d = 0; m_have_prev = 0; m_locked = 0; m_pend = 0; m_overrun = 0;
    m_cnt = 0; m_seq = 0; m_remaining = 0; m_code = '0; m_pend_data = '0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_valid_d = 0; m_have_prev = 0; m_locked = 0; m_pend = 0; m_overrun = 0;
        m_cnt = 0; m_seq = 0; m_remaining = 0; m_code = '0; m_pend_data = '0;
        exp_q.delete();
      end else begin
        s_cap = en && valid && !m_valid_d;
        s_ld = (m_remaining == 0) && m_pend;
        s_pend_before = m_pend;
        s_set = 0;
        if (!en) begin
          m_cnt = 0; m_have_prev = 0; m_locked = 0;
        end else if (s_cap) begin
          s_diff = int'(idac_fine) - int'(m_code[7:0]);
          if (s_diff < 0) s_diff = -s_diff;
          if (!m_have_prev) m_cnt = 0;
          else if (idac_coarse == m_code[15:8] && s_diff <= FT) m_cnt = (m_cnt < SN) ? m_cnt + 1 : SN;
          else m_cnt = 0;
          m_have_prev = 1;
          m_locked = (m_cnt == SN);
          m_code = {idac_coarse, idac_fine};
        end
        if (s_ld) begin
          exp_q.push_back(m_pend_data);
          m_remaining = FRAME_CYC;
          m_pend = 0;
        end else if (m_remaining > 0) begin
          m_remaining--;
        end
        if (s_cap) begin
          if (s_pend_before && !s_ld) s_set = 1;
          m_pend = 1;
          m_pend_data = {4'hA, m_locked, 3'(m_seq), idac_coarse, idac_fine};
          m_seq = (m_seq + 1) % 8;
        end
        if (s_set) m_overrun = 1;
        else if (clr_overrun) m_overrun = 0;
        m_valid_d = valid;
      end
    end
  end

  // Per-cycle output checks, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("code", 32'(code), 32'(m_code));
        check("locked", 32'(locked), 32'(m_locked));
        check("overrun", 32'(overrun), 32'(m_overrun));
        check("busy", 32'(busy), 32'(m_pend || m_remaining > 0));
        if (m_remaining == 0) check("tx_idle", 32'(tx), 32'd1);
      end
    end
  end

  // UART receiver / scoreboard monitor.
  bit          rx_active;
  int          rx_cnt, rx_n;
  logic [7:0]  rx_byte;
  logic [23:0] rx_frame, rx_exp;

  initial begin
    rx_active = 0; rx_cnt = 0; rx_n = 0; rx_byte = '0; rx_frame = '0; rx_exp = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rx_active = 0;
        rx_n = 0;
      end else if (!rx_active) begin
        if (tx == 1'b0) begin
          rx_active = 1;
          rx_cnt = 0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt == CD / 2) begin
          check("start_bit", 32'(tx), 32'd0);
        end else if (rx_cnt == 9 * CD + CD / 2) begin
          check("stop_bit", 32'(tx), 32'd1);
          rx_active = 0;
          rx_frame = {rx_frame[15:0], rx_byte};
          rx_n++;
          if (rx_n == 3) begin
            rx_n = 0;
            n_vec++;
            if (exp_q.size() == 0) begin
              n_bad++;
              $display("FAIL frame: got %06h, no frame expected at %0t", rx_frame, $time);
            end else begin
              rx_exp = exp_q.pop_front();
              if (rx_frame !== rx_exp) begin
                n_bad++;
                $display("FAIL frame: got %06h, expected %06h at %0t", rx_frame, rx_exp, $time);
              end else begin
                $display("frame %06h received ok at %0t", rx_frame, $time);
              end
            end
          end
        end else if (rx_cnt > CD && (rx_cnt % CD) == CD / 2) begin
          rx_byte = {tx, rx_byte[7:1]};
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [7:0] c, input logic [7:0] f, input int len, input int gap);
    idac_coarse = c;
    idac_fine = f;
    valid = 1'b1;
    tick(len);
    valid = 1'b0;
    tick(gap);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((m_pend || m_remaining > 0) && k < budget) begin
      tick(1);
      k++;
    end
    check("busy_after_wait", 32'(busy), 32'd0);
    tick(2);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  logic [7:0] lock_fines [5] = '{8'h40, 8'h41, 8'h40, 8'h41, 8'h41};

  initial begin
    #1 reset = 1'b1;
    tick(3);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_code", 32'(code), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    en = 1'b1;
    tick(2);

    // Single capture, frame A0 5A 31
    pulse(8'h5A, 8'h31, 3, 2);
    wait_idle(FRAME_CYC + 20);

    // Lock on the fifth consistent capture, drop on a 2-code jump
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pulse(8'h80, lock_fines[i], 2, 2);
      if (i == 3) check("locked_before5", 32'(locked), 32'd0);
      wait_idle(FRAME_CYC + 20);
    end
    check("locked_after5", 32'(locked), 32'd1);
    pulse(8'h80, 8'h43, 2, 2);
    check("locked_drop", 32'(locked), 32'd0);
    wait_idle(FRAME_CYC + 20);

    // Fine difference does not wrap
    pulse(8'h10, 8'h00, 2, 2);
    wait_idle(FRAME_CYC + 20);
    pulse(8'h10, 8'hFF, 2, 2);
    check("no_wrap_lock", 32'(locked), 32'd0);
    wait_idle(FRAME_CYC + 20);

    // Overwrites while a frame is in flight
    pulse(8'h21, 8'h01, 2, 8);
    pulse(8'h22, 8'h02, 2, 8);
    pulse(8'h23, 8'h03, 2, 8);
    check("overrun_set", 32'(overrun), 32'd1);
    idac_coarse = 8'h24;
    idac_fine = 8'h04;
    valid = 1'b1;
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    tick(1);
    valid = 1'b0;
    tick(2);
    check("overrun_set_wins", 32'(overrun), 32'd1);
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    check("overrun_clr", 32'(overrun), 32'd0);
    wait_idle(3 * FRAME_CYC + 20);

    // Long valid level gives one capture
    pulse(8'h30, 8'h05, 50, 5);
    wait_idle(FRAME_CYC + 20);

    // Lock, then drop en with a frame in flight
    for (int i = 0; i < 5; i++) pulse(8'h40, 8'h10, 2, 2);
    wait_idle(3 * FRAME_CYC + 20);
    check("locked_hold", 32'(locked), 32'd1);
    pulse(8'h40, 8'h10, 2, 20);
    en = 1'b0;
    tick(1);
    check("locked_en_off", 32'(locked), 32'd0);
    wait_idle(FRAME_CYC + 20);
    en = 1'b1;

    // Reset during data bit 3 of byte 1 (coarse 0x55, bit 3 = 0)
    pulse(8'h55, 8'h66, 2, 0);
    for (int k = 0; k < 20 && m_remaining != FRAME_CYC; k++) tick(1);
    tick(14 * CD + 1);
    check("tx_mid_bit3", 32'(tx), 32'd0);
    reset = 1'b1;
    #1;
    check("rst_mid_tx", 32'(tx), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    tick(2);
    reset = 1'b0;
    tick(3 * CD);
    pulse(8'h77, 8'h12, 2, 2);
    wait_idle(FRAME_CYC + 20);

    // Randomised captures
    for (int i = 0; i < 40; i++) begin
      clr_overrun = ($urandom_range(0, 7) == 0);
      en = ($urandom_range(0, 15) != 0);
      pulse(8'h60 + 8'($urandom_range(0, 1)), 8'h80 + 8'($urandom_range(0, 3)),
            int'($urandom_range(1, 4)), 0);
      clr_overrun = 1'b0;
      tick(int'($urandom_range(0, 90)));
    end
    en = 1'b1;
    wait_idle(4 * FRAME_CYC);
    tick(5);
    check("frames_left", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bg_trim_monitor.md
Name: bg_trim_monitor

Overview:
- Consumer-side companion to the bandgap SAR trim controller.
- Samples the controller's trim result (coarse/fine IDAC codes) each time the controller asserts its result-valid pulse.
- Judges lock: N consecutive results agree within a fine-code tolerance.
- Streams each result off-chip as a 3-byte UART 8N1 frame for characterisation and production test.

Parameters:
- CLK_DIV, 87, clk cycles per UART bit (10 MHz / 115200); legal 2..255.
- STABLE_N, 4, consecutive in-tolerance results required for lock; legal 1..15.
- FINE_TOL, 1, max absolute fine-code difference still counted as stable.

Ports:
- clk  in  1  system clock (10 MHz nominal).
- reset  in  1  asynchronous, active-high reset.
- en  in  1  monitor enable; 0 ignores captures and clears lock tracking.
- valid  in  1  result-valid from trim controller; level, may stay high several cycles.
- idac_coarse  in  8  coarse trim code.
- idac_fine  in  8  fine trim code.
- clr_overrun  in  1  clears sticky overrun.
- tx  out  1  UART serial output, idle high.
- busy  out  1  frame pending or in transmission.
- locked  out  1  trim result stable.
- code  out  16  last captured {coarse, fine}.
- overrun  out  1  sticky: pending frame overwritten before transmission.

Behaviour:
- Reset values (async, immediate):
  - tx=1, busy=0, locked=0, code=0, overrun=0.
  - seq=0, stable_cnt=0, have_prev=0, pending=0, TX state=IDLE.
  - valid_d=0.
- Capture event:
  - Occurs at an edge where en=1, valid=1 and valid_d=0; valid_d is valid registered each cycle.
  - Exactly one capture per valid high period.
  - code updates at that edge.
- Stability check at capture, against the previous code:
  - Stable means coarse equal AND |fine_new - fine_prev| <= FINE_TOL.
  - Difference is computed unsigned in 9 bits; no wrap, so 0x00 vs 0xFF gives 255.
- stable_cnt update at capture:
  - Stable: stable_cnt increments, saturating at STABLE_N.
  - Not stable: stable_cnt resets to 0.
  - First capture (have_prev=0): stable_cnt=0, have_prev set.
  - locked = (stable_cnt == STABLE_N), registered; updates the same edge as code.
- en=0: stable_cnt, have_prev and locked clear next edge. A frame already pending or in flight completes.
- Pending frame at capture:
  - bytes = {4'hA, locked_new, seq[2:0]}, coarse, fine.
  - locked_new is the value locked takes at this edge.
  - seq increments mod 8 per capture.
- Pending slot is one deep:
  - Capture while pending=1 and not being loaded this edge: overwrite pending, set overrun.
  - Capture on the same edge the TX loads pending: load takes the old data, new data becomes pending, no overrun.
- overrun clears on clr_overrun=1; set wins over clear in the same cycle.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE with pending=1: next edge loads shift buffer, pending=0, state=START, tx=0.
  - Each bit holds exactly CLK_DIV cycles.
  - DATA sends 8 bits LSB first; STOP drives tx=1.
  - After STOP of byte 0 or 1, go to START of the next byte (no idle gap).
  - After byte 2 STOP, return to IDLE.
  - Frame length is 30*CLK_DIV cycles. With pending=1 at IDLE, the next frame starts one cycle later.
- busy = pending | (state != IDLE).
- Reset mid-frame: tx returns to 1 immediately; the partial frame is discarded.

Test Plan:
- CLK_DIV=4. Apply reset, then a 3-cycle valid pulse with coarse=0x5A, fine=0x31.
  - code=0x5A31 one edge after valid rises; locked=0.
  - tx emits 0xA0, 0x5A, 0x31 LSB-first, each bit 4 cycles; frame 120 cycles; busy drops after.
- STABLE_N=4, FINE_TOL=1. Five captures with coarse=0x80, fine 0x40, 0x41, 0x40, 0x41, 0x41.
  - locked rises exactly at the 5th capture; that frame's header byte is 0xAC (seq=4, lock bit set).
  - A 6th capture with fine=0x43 drops locked at that edge.
- Boundary: capture fine=0x00 then fine=0xFF with the same coarse.
  - stable_cnt=0, no lock; no wrap in the difference.
- Three captures 10 cycles apart during one frame.
  - Only the latest is sent after the first frame; overrun=1.
  - clr_overrun pulse on the same cycle as a new overwrite leaves overrun=1.
- Hold valid high for 50 cycles: exactly one capture and one frame. Drop en during lock: locked=0 next edge, in-flight frame completes intact.
- Assert reset during DATA bit 3 of byte 1: tx=1 immediately, busy=0, no further frame bits. The next capture sends header seq=0.
